load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 80 ++++++++
 tb/tb_load_store_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory signals of the load/store unit
//   req_*   : core request (valid/ready handshake, we, funct3, addr, wdata)
//   resp_*  : one-cycle completion pulse with load data and misalignment flag
//   mem_*   : word-wide data memory port (registered read data on mem_rdata)
//   master  : core + memory side; slave : the LSU
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-wide memory
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (core request/response + data memory port)
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses without touching memory (resp_misaligned=1).
module load_store_unit (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD_RD, LD_WAIT, ST_RD, ST_MRG, ST_WR, RESP} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, rdata_q, ld_data, merged;
  logic [2:0]  f3_q;
  logic        mis_q, accept, mis;
  logic [7:0]  lb;
  logic [15:0] lh;
  // funct3[1]=1 covers 010 and the reserved 011/110/111, all handled as word
  assign accept = bus.req_valid && state == IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = (bus.req_funct3[1] && bus.req_addr[1:0] != 2'b00) ||
               (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]);
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !accept ? IDLE : mis ? RESP : !bus.req_we ? LD_RD :
                         bus.req_funct3[1] ? ST_WR : ST_RD;
      LD_RD:   state_n = LD_WAIT;
      LD_WAIT: state_n = RESP;
      ST_RD:   state_n = ST_MRG;
      ST_MRG:  state_n = ST_WR;
      ST_WR:   state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  assign lb = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lh = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign ld_data = f3_q[1] ? bus.mem_rdata :
                   f3_q[0] ? {{16{~f3_q[2] & lh[15]}}, lh} : {{24{~f3_q[2] & lb[7]}}, lb};
  always_comb begin
    merged = bus.mem_rdata;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end
  // rdata_q is only written on the edge entering RESP, so it holds between responses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
        mis_q   <= mis;
        if (mis) rdata_q <= '0;
      end
      if (state == LD_WAIT) rdata_q <= ld_data;
      if (state == ST_MRG) wdata_q <= merged;
      if (state == ST_WR) rdata_q <= '0;
    end
  assign bus.req_ready       = state == IDLE;
  assign bus.resp_valid      = state == RESP;
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_misaligned = state == RESP && mis_q;
  assign bus.mem_addr        = {addr_q[31:2], 2'b00};
  assign bus.mem_r_enable    = state == LD_RD || state == ST_RD;
  assign bus.mem_w_enable    = state == ST_WR;
  assign bus.mem_wdata       = state == ST_WR ? wdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a word memory
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n;
  load_store_unit_if bus ();
  load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_r_enable) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    if (bus.mem_w_enable) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end
  int both_cnt = 0;
  always @(negedge clk) if (bus.mem_r_enable && bus.mem_w_enable) both_cnt++;
  int errors = 0, checks = 0;
  int lat, nr, nw;
  logic [31:0] rd, wd_seen, ra_seen;
  logic mis;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tx(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    lat = 0; nr = 0; nw = 0; wd_seen = '0; ra_seen = '0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
      if (bus.mem_r_enable) begin nr++; ra_seen = bus.mem_addr; end
      if (bus.mem_w_enable) begin nw++; wd_seen = bus.mem_wdata; end
    end while (!bus.resp_valid && lat < 20);
    rd = bus.resp_rdata;
    mis = bus.resp_misaligned;
  endtask
  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] exp, input int exp_lat);
    tx(1'b0, f3, a, 32'h0);
    check(tag, rd, exp);
    check({tag, "_lat"}, lat, exp_lat);
  endtask
  logic [31:0] wlog [0:3];
  int wcyc [0:3];
  int nlog;
  logic rdy2, rdy3;
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    #22;
    check("rst_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_mis", bus.resp_misaligned, 0);
    check("rst_mem_r", bus.mem_r_enable, 0);
    check("rst_mem_w", bus.mem_w_enable, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    tx(1'b1, 3'b010, 32'h100, 32'h8899AABB);
    check("sw_lat", lat, 2); check("sw_nr", nr, 0); check("sw_nw", nw, 1);
    check("sw_wdata", wd_seen, 32'h8899AABB); check("sw_rdata", rd, 0);
    ld("lb_103", 3'b000, 32'h103, 32'hFFFFFF88, 3);
    check("lb_nr", nr, 1); check("lb_nw", nw, 0); check("lb_mem_addr", ra_seen, 32'h100);
    @(negedge clk);
    check("rdata_hold", bus.resp_rdata, 32'hFFFFFF88);
    check("resp_one_cycle", bus.resp_valid, 0);
    ld("lhu_102", 3'b101, 32'h102, 32'h00008899, 3);
    ld("lh_102", 3'b001, 32'h102, 32'hFFFF8899, 3);
    ld("lbu_100", 3'b100, 32'h100, 32'h000000BB, 3);
    ld("lh_100", 3'b001, 32'h100, 32'hFFFFAABB, 3);
    tx(1'b1, 3'b000, 32'h101, 32'h000000CC);
    check("sb_lat", lat, 4); check("sb_nr", nr, 1); check("sb_nw", nw, 1);
    check("sb_wdata", wd_seen, 32'h8899CCBB);
    ld("lw_after_sb", 3'b010, 32'h100, 32'h8899CCBB, 3);
    tx(1'b1, 3'b001, 32'h102, 32'hABCD1234);
    check("sh_lat", lat, 4); check("sh_wdata", wd_seen, 32'h1234CCBB);
    ld("f3_011", 3'b011, 32'h100, 32'h1234CCBB, 3);
    ld("f3_110", 3'b110, 32'h100, 32'h1234CCBB, 3);
`ifdef LSU_MISALIGN_CHECK_EN
    tx(1'b0, 3'b010, 32'h102, 32'h0);
    check("mis_lw_mis", mis, 1); check("mis_lw_rdata", rd, 0);
    check("mis_lw_lat", lat, 1); check("mis_lw_nr", nr, 0);
    tx(1'b1, 3'b001, 32'h101, 32'hFFFF);
    check("mis_sh_mis", mis, 1); check("mis_sh_nw", nw, 0); check("mis_sh_nr", nr, 0);
    ld("after_mis", 3'b010, 32'h100, 32'h1234CCBB, 3);
`else
    tx(1'b0, 3'b010, 32'h102, 32'h0);
    check("lw_102_mis", mis, 0); check("lw_102_rdata", rd, 32'h1234CCBB);
    check("lw_102_lat", lat, 3);
`endif
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h0000FFFF;
    @(posedge clk);
    @(negedge clk); bus.req_valid = 1'b0;
    nw = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", bus.req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_w_enable) nw++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_w_enable) nw++;
    end
    check("abort_nw", nw, 0);
    check("abort_ready_after", bus.req_ready, 1);
    ld("abort_word", 3'b010, 32'h100, 32'h1234CCBB, 3);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h104; bus.req_wdata = 32'h11111111;
    @(posedge clk);
    nlog = 0; rdy2 = 1'b0; rdy3 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.req_addr = 32'h108; bus.req_wdata = 32'h22222222; end
      if (c == 4) bus.req_valid = 1'b0;
      if (c == 2) rdy2 = bus.req_ready;
      if (c == 3) rdy3 = bus.req_ready;
      if (bus.mem_w_enable && nlog < 4) begin
        wlog[nlog] = bus.mem_wdata; wcyc[nlog] = c; nlog++;
      end
    end
    check("b2b_ready_resp", rdy2, 0);
    check("b2b_ready_idle", rdy3, 1);
    check("b2b_nwrites", nlog, 2);
    check("b2b_w0", wlog[0], 32'h11111111); check("b2b_c0", wcyc[0], 1);
    check("b2b_w1", wlog[1], 32'h22222222); check("b2b_c1", wcyc[1], 4);
    ld("b2b_mem104", 3'b010, 32'h104, 32'h11111111, 3);
    ld("b2b_mem108", 3'b010, 32'h108, 32'h22222222, 3);
    check("no_dual_strobe", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
